// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over imem req/ack and hands them to Control
// over valid/ready, honours redirects, halts on ECALL/EBREAK. Define FETCH_PERF_EN for perf counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] ECALL_WORD = 32'h0000_0073,
  parameter logic [31:0] EBRK_WORD  = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, HALT, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] instr_q, instr_pc_q;

  logic active, redir_ok, redir_bad, take_ack, accept, halting, begin_fetch;

  assign active      = (state == REQ) || (state == HOLD);
  assign redir_ok    = active && redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad   = active && redirect && (redirect_pc[1:0] != 2'b00);
  // A response is only kept when no redirect lands in the same cycle and it is not a stale one.
  assign take_ack    = (state == REQ) && imem_ack && !redirect && !kill;
  assign accept      = (state == HOLD) && instr_ready && !redirect;
  assign halting     = (instr_q == ECALL_WORD) || (instr_q == EBRK_WORD);
  assign begin_fetch = start && ((state == IDLE) || (state == HALT));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch would infer a latch.
    state_nxt = state;
    case (state)
      IDLE, HALT: if (start) state_nxt = REQ;
      REQ: begin
        if (redir_bad)     state_nxt = ERR;
        else if (redir_ok) state_nxt = REQ;
        else if (take_ack) state_nxt = HOLD;
      end
      HOLD: begin
        if (redir_bad)     state_nxt = ERR;
        else if (redir_ok) state_nxt = REQ;
        else if (accept)   state_nxt = halting ? HALT : REQ;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state == REQ);
    instr_valid  = (state == HOLD);
    done         = (state == HALT) || (state == ERR);
    misalign_err = (state == ERR);
  end

  assign imem_addr = pc;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      pc         <= RESET_PC;
      kill       <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (begin_fetch) begin
      pc   <= RESET_PC;
      kill <= 1'b0;
    end else if (redir_ok) begin
      pc   <= redirect_pc;
      // The outstanding request still owes one ack; mark it stale unless it arrives right now.
      kill <= (state == REQ) && !imem_ack;
    end else begin
      if ((state == REQ) && imem_ack) kill <= 1'b0;
      if (take_ack) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
      if (accept && !halting) pc <= pc + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || begin_fetch) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if ((state == REQ) && !imem_ack && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: redirect vector table, hand-written corner sequences and a
// randomized run checked against an accepted-instruction stream model.
module tb_instr_fetch_unit;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] FAR   = 32'hFFFF_0000;

  logic        clk;
  logic        rst, start, done;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Instruction memory model: latches the address when a request appears, acks lat cycles later.
  int          lat = 1;
  logic [31:0] halt_addr = FAR;
  logic [31:0] halt_word = ECALL;
  bit          nop_fill = 1'b0;
  bit          m_pending = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return halt_word;
    if (nop_fill) return NOP;
    return 32'h8000_0000 | a;
  endfunction

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_ack) imem_ack = 1'b0;
      else begin
        if (!m_pending && imem_req) begin
          m_pending = 1'b1;
          m_cnt     = 0;
          m_addr    = imem_addr;
        end
        if (m_pending) begin
          if (m_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(m_addr);
            m_pending  = 1'b0;
          end else m_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (5) step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 60) begin
      step();
      n++;
    end
    if (!instr_valid) check1(name, instr_valid, 1'b1);
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic        exp_err;
    logic [31:0] exp_next;
  } redir_vec_t;

  redir_vec_t vecs[6];

  initial begin
    logic [31:0] pcs[$];
    logic [31:0] words[$];
    logic        prev_valid, prev_req, running;
    logic [31:0] exp_pc;
    int          n;

    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0000_0104};
    vecs[1] = '{32'h0000_0102, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'h0000_0101, 1'b1, 32'h0000_0000};
    vecs[3] = '{32'h0000_0103, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0004};

    // Reset state, then the basic program: three NOPs and ECALL, ack latency 2, ready held high.
    do_reset();
    check1("rst_done", done, 1'b0);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_err", misalign_err, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_stall_count", stall_count, 32'h0);
`endif
    lat = 2; nop_fill = 1'b1; halt_addr = 32'hC; halt_word = ECALL; instr_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!done && n < 200) begin
      if (instr_valid) begin
        pcs.push_back(instr_pc);
        words.push_back(instr);
      end
      step();
      n++;
    end
    check1("t1_done", done, 1'b1);
    check("t1_count", 32'(pcs.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < pcs.size()) begin
        check("t1_pc", pcs[i], 32'(4 * i));
        check("t1_word", words[i], (i == 3) ? ECALL : NOP);
      end
    end
    check1("t1_halt_req", imem_req, 1'b0);
    check1("t1_halt_valid", instr_valid, 1'b0);
`ifdef FETCH_PERF_EN
    check("t6_fetch_count", fetch_count, 32'd4);
    check("t6_stall_count", stall_count, 32'd8);
`endif

    // Ack-to-valid latency, then a 5-cycle hold with ready low.
    do_reset();
    lat = 1; nop_fill = 1'b0; halt_addr = FAR; instr_ready = 1'b0;
    pulse_start();
    n = 0;
    prev_valid = instr_valid;
    while (!imem_ack && n < 20) begin
      prev_valid = instr_valid;
      step();
      n++;
    end
    check1("t2_valid_before_ack", prev_valid, 1'b0);
    check1("t2_ack_to_valid", instr_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_instr", instr, mem_word(32'h0));
      check("t2_hold_pc", instr_pc, 32'h0);
      check1("t2_hold_req", imem_req, 1'b0);
      check1("t2_hold_valid", instr_valid, 1'b1);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check1("t2_next_req", imem_req, 1'b1);
    check("t2_next_addr", imem_addr, 32'h4);
    check1("t2_valid_drop", instr_valid, 1'b0);

    // Redirect while a request is outstanding: the stale response must be dropped.
    do_reset();
    lat = 3; nop_fill = 1'b0; halt_addr = FAR; instr_ready = 1'b0;
    pulse_start();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check1("t3_req_held", imem_req, 1'b1);
    check("t3_addr", imem_addr, 32'h100);
    check1("t3_valid", instr_valid, 1'b0);
    wait_valid("t3_timeout");
    check("t3_instr_pc", instr_pc, 32'h100);
    check("t3_instr", instr, mem_word(32'h100));

    // Misaligned redirect is sticky through start and cleared only by reset.
    do_reset();
    lat = 1; instr_ready = 1'b0;
    pulse_start();
    wait_valid("t4_timeout");
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    check1("t4_err", misalign_err, 1'b1);
    check1("t4_done", done, 1'b1);
    pulse_start();
    repeat (3) step();
    check1("t4_err_sticky", misalign_err, 1'b1);
    check1("t4_done_sticky", done, 1'b1);
    check1("t4_req_off", imem_req, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("t4_err_cleared", misalign_err, 1'b0);
    check1("t4_done_cleared", done, 1'b0);

    // Reset in the middle of a request with the ack landing just after it; redirect in IDLE ignored.
    do_reset();
    lat = 2; instr_ready = 1'b0;
    pulse_start();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("t5_valid", instr_valid, 1'b0);
    check1("t5_req", imem_req, 1'b0);
    check1("t5_done", done, 1'b0);
    step();
    step();
    check1("t5_ack_ignored_valid", instr_valid, 1'b0);
    check1("t5_ack_ignored_req", imem_req, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("t5_idle_redirect", imem_addr, 32'h0);
    repeat (3) step();
    pulse_start();
    check("t5_restart_addr", imem_addr, 32'h0);
    wait_valid("t5_timeout");
    check("t5_instr_pc", instr_pc, 32'h0);
    check("t5_instr", instr, mem_word(32'h0));

    // Redirect vector table, issued while an instruction is held.
    foreach (vecs[k]) begin
      do_reset();
      lat = 1; nop_fill = 1'b0; halt_addr = FAR; instr_ready = 1'b0;
      pulse_start();
      wait_valid("tab_timeout");
      redirect = 1'b1; redirect_pc = vecs[k].rpc;
      step();
      redirect = 1'b0;
      check1("tab_err", misalign_err, vecs[k].exp_err);
      check1("tab_done", done, vecs[k].exp_err);
      check1("tab_valid_drop", instr_valid, 1'b0);
      check1("tab_req", imem_req, !vecs[k].exp_err);
      if (!vecs[k].exp_err) begin
        check("tab_addr", imem_addr, vecs[k].rpc);
        wait_valid("tab_timeout2");
        check("tab_instr_pc", instr_pc, vecs[k].rpc);
        check("tab_instr", instr, mem_word(vecs[k].rpc));
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("tab_next_addr", imem_addr, vecs[k].exp_next);
        check1("tab_next_req", imem_req, 1'b1);
      end
    end

    // Randomized: the accepted stream must follow sequential PCs, redirects and halt on the halt word.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      lat = $urandom_range(0, 3);
      nop_fill = 1'b0;
      halt_addr = 32'(4 * $urandom_range(6, 30));
      halt_word = ep[0] ? EBRK : ECALL;
      pulse_start();
      exp_pc = '0;
      running = 1'b1;
      prev_req = imem_req;
      for (int c = 0; c < 3000 && running; c++) begin
        instr_ready = ($urandom_range(0, 9) < 7);
        redirect = (c < 300) && ($urandom_range(0, 11) == 0);
        redirect_pc = 32'(4 * $urandom_range(0, 32'(halt_addr >> 2)));
        if (redirect) exp_pc = redirect_pc;
        else if (instr_valid && instr_ready) begin
          check("rnd_pc", instr_pc, exp_pc);
          check("rnd_instr", instr, mem_word(exp_pc));
          if (exp_pc == halt_addr) running = 1'b0;
          else exp_pc = exp_pc + 32'd4;
        end
        step();
        redirect = 1'b0;
        if (prev_req && !imem_req && running) check1("rnd_req_until_ack", imem_ack, 1'b1);
        prev_req = imem_req;
      end
      instr_ready = 1'b0;
      check1("rnd_done", done, 1'b1);
      check1("rnd_halt_req", imem_req, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
